// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding / hazard controller.
package fwd_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  // Forwarding select encodings: 0 = register file, k = result held in stage k
  localparam int unsigned FWD_REGFILE = 0;
  localparam int unsigned FWD_EXE     = 1;
  localparam int unsigned FWD_MEM     = 2;
  localparam int unsigned FWD_WB      = 3;

  typedef enum logic [1:0] {
    RUN,
    LU_STALL,
    MEM_WAIT
  } state_t;

  // Destination info of one in-flight instruction
  typedef struct packed {
    logic                  valid;
    logic                  regwrite;
    logic                  is_load;
    logic [REG_ADDR_W-1:0] rd;
  } sb_entry_t;

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// ID-side bundle between the pipeline (master) and the hazard controller (slave).
interface fwd_hazard_ctrl_if #(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned SEL_W   = 2
);

  logic                      id_valid;
  logic [NUM_SRC*ADDR_W-1:0] id_rs_addr;
  logic [NUM_SRC-1:0]        id_rs_used;
  logic [ADDR_W-1:0]         id_rd_addr;
  logic                      id_regwrite;
  logic                      id_is_load;
  logic                      flush;
  logic                      dmem_wait;
  logic [NUM_SRC*SEL_W-1:0]  fwd_sel;
  logic                      stall_id;
  logic                      bubble_exe;
  logic                      freeze_all;

  modport master (
    output id_valid, id_rs_addr, id_rs_used, id_rd_addr, id_regwrite, id_is_load,
           flush, dmem_wait,
    input  fwd_sel, stall_id, bubble_exe, freeze_all
  );

  modport slave (
    input  id_valid, id_rs_addr, id_rs_used, id_rd_addr, id_regwrite, id_is_load,
           flush, dmem_wait,
    output fwd_sel, stall_id, bubble_exe, freeze_all
  );

endinterface

// File: rtl/fwd_match_src.sv
// Per-source operand matcher: priority-encodes the youngest producing stage.
// FWD_WB_BYPASS_EN: when defined, the last (WB) stage may also be forwarded from.
module fwd_match_src
  import fwd_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned SEL_W      = 2
) (
  input  logic [ADDR_W-1:0]        rs_addr,
  input  logic                     rs_used,
  input  sb_entry_t [NUM_STAGES:1] stg,
  output logic [SEL_W-1:0]         sel_c,
  output logic                     load_hit_c
);

`ifdef FWD_WB_BYPASS_EN
  localparam int unsigned MATCH_DEPTH = NUM_STAGES;
`else
  // WB excluded: the register file writes through, so WB results are read directly
  localparam int unsigned MATCH_DEPTH = NUM_STAGES - 1;
`endif

  logic [NUM_STAGES:1] match;
  logic                unused_stg;

  // Some entry fields (e.g. is_load beyond EXE) are not needed for matching
  assign unused_stg = ^stg;

  // Match per stage; x0 is hard-wired zero and never produces a hazard
  always_comb begin
    match = '0;
    for (int unsigned k = 1; k <= MATCH_DEPTH; k++) begin
      match[k] = rs_used && stg[k].valid && stg[k].regwrite
                 && (stg[k].rd != '0) && (stg[k].rd == REG_ADDR_W'(rs_addr));
    end
  end

  // Youngest producer (lowest stage index) wins
  always_comb begin
    sel_c      = SEL_W'(FWD_REGFILE);
    load_hit_c = 1'b0;
    for (int unsigned k = MATCH_DEPTH; k >= 1; k--) begin
      if (match[k]) sel_c = SEL_W'(k);
    end
    load_hit_c = match[1] && stg[1].is_load;
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard controller beside ID: operand selects, load-use stall,
// and global freeze while data memory waits.
// FWD_WB_BYPASS_EN: when defined, forwarding from the WB stage is enabled.
module fwd_hazard_ctrl
  import fwd_pkg::*;
#(
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned SEL_W      = 2
) (
  input logic             clk,
  input logic             rst_n,
  fwd_hazard_ctrl_if.slave bus
);

  sb_entry_t [NUM_STAGES:1] stg;
  logic [NUM_SRC-1:0]       src_load_hit;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel_c;
  logic                     lu_hit;
  state_t                   state;
  state_t                   state_next;
  logic                     stall_id_c;
  logic                     bubble_exe_c;
  logic                     freeze_all_c;

  // One matcher per source operand
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_match_src #(
      .NUM_STAGES (NUM_STAGES),
      .ADDR_W     (ADDR_W),
      .SEL_W      (SEL_W)
    ) u_match (
      .rs_addr    (bus.id_rs_addr[i*ADDR_W +: ADDR_W]),
      .rs_used    (bus.id_rs_used[i]),
      .stg        (stg),
      .sel_c      (fwd_sel_c[i*SEL_W +: SEL_W]),
      .load_hit_c (src_load_hit[i])
    );
  end

  assign lu_hit = |src_load_hit;

  // Stage scoreboard: shifts each unfrozen cycle, a bubble enters on stall/flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg <= '0;
    end else if (!bus.dmem_wait) begin
      for (int unsigned k = NUM_STAGES; k >= 2; k--) begin
        stg[k] <= stg[k-1];
      end
      if (bus.id_valid && !bus.flush && !lu_hit) begin
        stg[1] <= '{valid:    1'b1,
                    regwrite: bus.id_regwrite,
                    is_load:  bus.id_is_load,
                    rd:       REG_ADDR_W'(bus.id_rd_addr)};
      end else begin
        stg[1] <= '0;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_next;
  end

  // Next state and stall controls; every state re-evaluates hazards against the
  // current scoreboard, the state only records why the pipeline is held
  always_comb begin
    state_next   = state;
    stall_id_c   = 1'b0;
    bubble_exe_c = 1'b0;
    freeze_all_c = 1'b0;
    if (bus.dmem_wait) begin
      state_next   = MEM_WAIT;
      freeze_all_c = 1'b1;
      stall_id_c   = 1'b1;
    end else begin
      state_next = RUN;
      if (lu_hit) begin
        bubble_exe_c = 1'b1;
        if (!bus.flush) begin
          stall_id_c = 1'b1;
          state_next = LU_STALL;
        end
      end
    end
  end

  assign bus.fwd_sel    = fwd_sel_c;
  assign bus.stall_id   = stall_id_c;
  assign bus.bubble_exe = bubble_exe_c;
  assign bus.freeze_all = freeze_all_c;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: per-cycle instruction-level model plus
// directed vectors with literal expectations.
module tb_fwd_hazard_ctrl;
  import fwd_pkg::*;

  localparam int unsigned NSRC = 2;
  localparam int unsigned NSTG = 3;
  localparam int unsigned AW   = 5;
  localparam int unsigned SW   = 2;
`ifdef FWD_WB_BYPASS_EN
  localparam int DEPTH = 3;
  localparam int WB_SEL = FWD_WB;
`else
  localparam int DEPTH = 2;
  localparam int WB_SEL = FWD_REGFILE;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fwd_hazard_ctrl_if #(.NUM_SRC(NSRC), .ADDR_W(AW), .SEL_W(SW)) bus ();

  fwd_hazard_ctrl #(
    .NUM_SRC(NSRC), .NUM_STAGES(NSTG), .ADDR_W(AW), .SEL_W(SW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: list of in-flight instructions, index 1 = just left ID
  logic       m_v [1:3];
  logic       m_we[1:3];
  logic       m_ld[1:3];
  logic [4:0] m_rd[1:3];
  logic       n_v [1:3];
  logic       n_we[1:3];
  logic       n_ld[1:3];
  logic [4:0] n_rd[1:3];

  function automatic int producer(input logic [4:0] rs, input logic used);
    if (!used || rs == 5'd0) return 0;
    for (int k = 1; k <= DEPTH; k++)
      if (m_v[k] && m_we[k] && m_rd[k] == rs) return k;
    return 0;
  endfunction

  int  e_sel0, e_sel1;
  logic e_lu, e_stall, e_bubble, e_freeze;

  // Compare DUT against the model each cycle, then compute the model's next contents
  always @(negedge clk) begin
    e_sel0 = producer(bus.id_rs_addr[4:0], bus.id_rs_used[0]);
    e_sel1 = producer(bus.id_rs_addr[9:5], bus.id_rs_used[1]);
    e_lu   = m_ld[1] && (e_sel0 == 1 || e_sel1 == 1);
    if (bus.dmem_wait) begin
      e_stall = 1'b1; e_bubble = 1'b0; e_freeze = 1'b1;
    end else begin
      e_stall = e_lu && !bus.flush; e_bubble = e_lu; e_freeze = 1'b0;
    end
    if (cmp_en) begin
      chk("m_fwd_sel0", int'(bus.fwd_sel[1:0]), e_sel0);
      chk("m_fwd_sel1", int'(bus.fwd_sel[3:2]), e_sel1);
      chk("m_stall_id", int'(bus.stall_id), int'(e_stall));
      chk("m_bubble_exe", int'(bus.bubble_exe), int'(e_bubble));
      chk("m_freeze_all", int'(bus.freeze_all), int'(e_freeze));
    end
    for (int k = 1; k <= 3; k++) begin
      n_v[k] = m_v[k]; n_we[k] = m_we[k]; n_ld[k] = m_ld[k]; n_rd[k] = m_rd[k];
    end
    if (!bus.dmem_wait) begin
      for (int k = 3; k >= 2; k--) begin
        n_v[k] = m_v[k-1]; n_we[k] = m_we[k-1]; n_ld[k] = m_ld[k-1]; n_rd[k] = m_rd[k-1];
      end
      if (bus.id_valid && !bus.flush && !e_lu) begin
        n_v[1] = 1'b1; n_we[1] = bus.id_regwrite; n_ld[1] = bus.id_is_load;
        n_rd[1] = bus.id_rd_addr;
      end else begin
        n_v[1] = 1'b0; n_we[1] = 1'b0; n_ld[1] = 1'b0; n_rd[1] = 5'd0;
      end
    end
  end

  // Model state update with asynchronous clear
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= 3; k++) begin
        m_v[k] <= 1'b0; m_we[k] <= 1'b0; m_ld[k] <= 1'b0; m_rd[k] <= 5'd0;
      end
    end else begin
      for (int k = 1; k <= 3; k++) begin
        m_v[k] <= n_v[k]; m_we[k] <= n_we[k]; m_ld[k] <= n_ld[k]; m_rd[k] <= n_rd[k];
      end
    end
  end

  task automatic set_in(input int v, input int rs1, input int u1, input int rs2, input int u2,
                        input int rd, input int we, input int ld, input int fl, input int dw);
    bus.id_valid    = 1'(v);
    bus.id_rs_addr  = {5'(rs2), 5'(rs1)};
    bus.id_rs_used  = {1'(u2), 1'(u1)};
    bus.id_rd_addr  = 5'(rd);
    bus.id_regwrite = 1'(we);
    bus.id_is_load  = 1'(ld);
    bus.flush       = 1'(fl);
    bus.dmem_wait   = 1'(dw);
  endtask

  // Present one ID vector just after the clock edge
  task automatic drive(input int v, input int rs1, input int u1, input int rs2, input int u2,
                       input int rd, input int we, input int ld, input int fl, input int dw);
    @(posedge clk);
    #1;
    set_in(v, rs1, u1, rs2, u2, rd, we, ld, fl, dw);
  endtask

  // Literal expectation for the current cycle
  task automatic lit(input string name, input int s0, input int s1, input int st,
                     input int bu, input int fr);
    @(negedge clk);
    chk({name, "_sel0"}, int'(bus.fwd_sel[1:0]), s0);
    chk({name, "_sel1"}, int'(bus.fwd_sel[3:2]), s1);
    chk({name, "_stall"}, int'(bus.stall_id), st);
    chk({name, "_bubble"}, int'(bus.bubble_exe), bu);
    chk({name, "_freeze"}, int'(bus.freeze_all), fr);
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    cmp_en = 1'b1;
    lit("reset", 0, 0, 0, 0, 0);
    #2 rst_n = 1'b1;

    // add x5,x1,x2 ; add x6,x5,x0
    drive(1, 1, 1, 2, 1, 5, 1, 0, 0, 0); lit("add_x5", 0, 0, 0, 0, 0);
    drive(1, 5, 1, 0, 1, 6, 1, 0, 0, 0); lit("fwd_exe", FWD_EXE, 0, 0, 0, 0);
    // lw x7 ; sub x8,x1,x7 (stall, then forward from MEM)
    drive(1, 1, 1, 0, 0, 7, 1, 1, 0, 0); lit("lw_x7", 0, 0, 0, 0, 0);
    drive(1, 1, 1, 7, 1, 8, 1, 0, 0, 0); lit("lu_stall", 0, FWD_EXE, 1, 1, 0);
    drive(1, 1, 1, 7, 1, 8, 1, 0, 0, 0); lit("lu_fwd_mem", 0, FWD_MEM, 0, 0, 0);
    // x9 in EXE and MEM
    drive(1, 1, 1, 0, 0, 9, 1, 0, 0, 0); lit("x9_a", 0, 0, 0, 0, 0);
    drive(1, 2, 1, 0, 0, 9, 1, 0, 0, 0); lit("x9_b", 0, 0, 0, 0, 0);
    drive(1, 9, 1, 9, 1, 10, 1, 0, 0, 0); lit("youngest", FWD_EXE, FWD_EXE, 0, 0, 0);
    drive(1, 10, 1, 0, 1, 12, 1, 0, 0, 0); lit("x10_exe", FWD_EXE, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 10, 1, 12, 1, 13, 1, 0, 0, 0); lit("wb_stage", WB_SEL, FWD_MEM, 0, 0, 0);
    // x0 writes, load to x0, reads of x0
    drive(1, 1, 1, 0, 0, 0, 1, 0, 0, 0);
    drive(1, 1, 1, 0, 0, 0, 1, 1, 0, 0);
    drive(1, 0, 1, 0, 1, 14, 1, 0, 0, 0); lit("x0_read", 0, 0, 0, 0, 0);
    // load-use under a 3-cycle memory wait
    drive(1, 1, 1, 0, 0, 15, 1, 1, 0, 0); lit("lw_x15", 0, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      drive(1, 15, 1, 2, 1, 16, 1, 0, 0, 1); lit("freeze", FWD_EXE, 0, 1, 0, 1);
    end
    drive(1, 15, 1, 2, 1, 16, 1, 0, 0, 0); lit("post_freeze", FWD_EXE, 0, 1, 1, 0);
    drive(1, 15, 1, 2, 1, 16, 1, 0, 0, 0); lit("one_bubble", FWD_MEM, 0, 0, 0, 0);
    // reset pulsed during the load-use stall
    drive(1, 1, 1, 0, 0, 17, 1, 1, 0, 0);
    drive(1, 17, 1, 0, 1, 18, 1, 0, 0, 0); lit("lu_pre_rst", FWD_EXE, 0, 1, 1, 0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    lit("rst_mid", 0, 0, 0, 0, 0);
    #2 rst_n = 1'b1;
    drive(1, 17, 1, 0, 1, 18, 1, 0, 0, 0); lit("after_rst", 0, 0, 0, 0, 0);
    // flush concurrent with load-use
    drive(1, 1, 1, 0, 0, 19, 1, 1, 0, 0);
    drive(1, 19, 1, 0, 0, 20, 1, 0, 1, 0); lit("flush_lu", FWD_EXE, 0, 0, 1, 0);
    drive(1, 19, 1, 0, 0, 21, 1, 0, 0, 0); lit("after_flush", FWD_MEM, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); lit("idle", 0, 0, 0, 0, 0);

    @(posedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
